apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 177 +++++++++++++++++
 tb/tb_apb_master.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_master
// Purpose  : Single-command APB master serving two slaves. A command is
//            accepted in IDLE, decoded on addr[7:6] (00 -> slave 1,
//            01 -> slave 2, 1x -> decode error), and run as a SETUP/ACCESS
//            bus cycle. A wait-state counter aborts the transfer after
//            TIMEOUT ACCESS cycles without PREADY. Each command ends in a
//            single-cycle rsp_valid pulse carrying read data and an error flag.
// Ports    : PCLK, PRESET              clock, async active-high reset
//            cmd_valid/ready/write/addr/wdata   command handshake
//            rsp_valid/rdata/err       one-cycle completion pulse
//            PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA   APB request
//            PRDATA1/2, PREADY1/2      APB completion from each slave
// Revision : 1.0  initial release
// ============================================================================
module apb_master #(
  parameter int TIMEOUT = 16
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       PSEL1,
  output logic       PSEL2,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA1,
  input  logic [7:0] PRDATA2,
  input  logic       PREADY1,
  input  logic       PREADY2
);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_setup  = 2'd1;
  localparam logic [1:0] c_st_access = 2'd2;

  // Count value at which the next low-PREADY ACCESS cycle is the last allowed.
  localparam logic [7:0] c_tmo_last  = 8'(TIMEOUT - 1);

  logic [1:0] state_q, state_d;
  logic       rdy_q;      // low until the first edge after reset release
  logic       sel_q;      // 0 = slave 1, 1 = slave 2
  logic       pwrite_q;
  logic [7:0] paddr_q;
  logic [7:0] pwdata_q;
  logic [7:0] cnt_q;
  logic       rsp_valid_q;
  logic       rsp_err_q;
  logic [7:0] rsp_rdata_q;

  logic       w_accept;
  logic       w_dec_err;
  logic       w_ready_sel;
  logic [7:0] w_rdata_sel;
  logic       w_timeout;

  assign w_accept    = cmd_valid & cmd_ready;
  assign w_dec_err   = cmd_addr[7];
  // Only the selected slave's handshake is observed.
  assign w_ready_sel = sel_q ? PREADY2 : PREADY1;
  assign w_rdata_sel = sel_q ? PRDATA2 : PRDATA1;
  assign w_timeout   = ~w_ready_sel & (cnt_q == c_tmo_last);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= c_st_idle;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle: begin
        // Decode errors complete without a bus cycle.
        if (w_accept && !w_dec_err) begin
          state_d = c_st_setup;
        end
      end
      c_st_setup: begin
        state_d = c_st_access;
      end
      c_st_access: begin
        if (w_ready_sel || w_timeout) begin
          state_d = c_st_idle;
        end
      end
      default: begin
        state_d = c_st_idle;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs. Bus strobes are decoded from the state register so that an
  // asynchronous reset drops them without waiting for a clock edge.
  // --------------------------------------------------------------------------
  always_comb begin
    cmd_ready = (state_q == c_st_idle) & rdy_q;
    PSEL1     = (state_q != c_st_idle) & ~sel_q;
    PSEL2     = (state_q != c_st_idle) &  sel_q;
    PENABLE   = (state_q == c_st_access);
    PWRITE    = pwrite_q;
    PADDR     = paddr_q;
    PWDATA    = pwdata_q;
    rsp_valid = rsp_valid_q;
    rsp_err   = rsp_err_q;
    rsp_rdata = rsp_rdata_q;
  end

  // --------------------------------------------------------------------------
  // Command capture, wait-state counter and response generation
  // --------------------------------------------------------------------------
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rdy_q       <= 1'b0;
      sel_q       <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= 8'h00;
      pwdata_q    <= 8'h00;
      cnt_q       <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 8'h00;
    end else begin
      rdy_q       <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 8'h00;

      if (w_accept) begin
        if (w_dec_err) begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b1;
        end else begin
          // Bus fields are only reloaded for a real transfer; they hold
          // their previous values across decode errors and idle periods.
          sel_q    <= cmd_addr[6];
          paddr_q  <= cmd_addr;
          pwrite_q <= cmd_write;
          pwdata_q <= cmd_write ? cmd_wdata : 8'h00;
          cnt_q    <= 8'h00;
        end
      end

      if (state_q == c_st_access) begin
        if (w_ready_sel) begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= pwrite_q ? 8'h00 : w_rdata_sel;
        end else if (w_timeout) begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master
// Purpose  : Self-checking bench for apb_master. Commands are issued at
//            transaction level; expected bus activity, response latency,
//            error flag and read data are computed from the wait-state count
//            the bench's slave model inserts.
// Revision : 1.0  initial release
// ============================================================================
module tb_apb_master;

  localparam int c_tmo = 4;

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       PSEL1, PSEL2, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA;
  logic [7:0] PRDATA1 = 8'h00;
  logic [7:0] PRDATA2 = 8'h00;
  logic       PREADY1 = 1'b0;
  logic       PREADY2 = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // Last bus fields of a real transfer, which the master must keep driving.
  logic [7:0] last_paddr  = 8'h00;
  logic [7:0] last_pwdata = 8'h00;
  logic       last_pwrite = 1'b0;

  apb_master #(.TIMEOUT(c_tmo)) u_dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSEL1     (PSEL1),
    .PSEL2     (PSEL2),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA1   (PRDATA1),
    .PRDATA2   (PRDATA2),
    .PREADY1   (PREADY1),
    .PREADY2   (PREADY2)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic junk_slaves();
    PREADY1 = 1'($urandom);
    PREADY2 = 1'($urandom);
    PRDATA1 = 8'($urandom);
    PRDATA2 = 8'($urandom);
  endtask

  // Idle cycles: nothing on the bus, no response, bus fields held.
  task automatic idle(input int n);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = 8'($urandom);
    cmd_wdata = 8'($urandom);
    for (int i = 0; i < n; i++) begin
      junk_slaves();
      @(negedge PCLK);
      chk("idle_ready", 32'(cmd_ready), 32'd1);
      chk("idle_quiet", 32'({rsp_valid, PSEL1, PSEL2, PENABLE}), 32'd0);
      chk("idle_paddr", 32'(PADDR), 32'(last_paddr));
    end
  endtask

  // One command. Called and returns at a negedge. w = number of ACCESS
  // cycles the selected slave holds PREADY low before raising it.
  task automatic do_txn(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                        input int w, input logic hold_valid, input logic [7:0] rdv);
    logic       dec_err, sel, exp_err, got, err_o, psel_me, psel_ot, rdy;
    logic [7:0] rd_o, exp_rd;
    int         acc, idx, lat, psel_n, pen_n, other_n, bad_n;
    dec_err = addr[7];
    sel     = addr[6];
    acc     = (w < c_tmo) ? w + 1 : c_tmo;
    exp_err = dec_err || (w >= c_tmo);
    exp_rd  = 8'h00;
    got = 1'b0; err_o = 1'b0; rd_o = 8'h00;
    idx = 0; lat = 0; psel_n = 0; pen_n = 0; other_n = 0; bad_n = 0;

    chk("cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    junk_slaves();
    @(posedge PCLK);
    #1;
    // Anything presented while busy must be ignored.
    cmd_valid = hold_valid;
    cmd_write = 1'($urandom);
    cmd_addr  = 8'($urandom);
    cmd_wdata = 8'($urandom);
    if (!dec_err) begin
      last_paddr  = addr;
      last_pwrite = wr;
      last_pwdata = wr ? wdata : 8'h00;
    end

    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge PCLK);
      psel_me = sel ? PSEL2 : PSEL1;
      psel_ot = sel ? PSEL1 : PSEL2;
      if (psel_me) psel_n++;
      if (psel_ot) other_n++;
      if (PENABLE) pen_n++;
      if (psel_me && (PADDR !== addr || PWRITE !== wr || PWDATA !== (wr ? wdata : 8'h00)))
        bad_n++;
      if (rsp_valid) begin
        got   = 1'b1;
        lat   = c;
        err_o = rsp_err;
        rd_o  = rsp_rdata;
      end
      junk_slaves();
      if (!dec_err && psel_me && PENABLE) begin
        idx++;
        rdy = (idx == w + 1);
        if (sel) PREADY2 = rdy; else PREADY1 = rdy;
        if (rdy) begin
          if (sel) PRDATA2 = rdv; else PRDATA1 = rdv;
          if (!wr) exp_rd = rdv;
        end
      end
    end

    chk("rsp_latency", 32'(lat), dec_err ? 32'd1 : 32'(acc + 2));
    chk("rsp_err", 32'(err_o), 32'(exp_err));
    chk("rsp_rdata", 32'(rd_o), 32'(exp_rd));
    chk("psel_cycles", 32'(psel_n), dec_err ? 32'd0 : 32'(acc + 1));
    chk("penable_cycles", 32'(pen_n), dec_err ? 32'd0 : 32'(acc));
    chk("other_psel", 32'(other_n), 32'd0);
    chk("bus_fields", 32'(bad_n), 32'd0);
    chk("paddr_hold", 32'(PADDR), 32'(last_paddr));
    chk("pwdata_hold", 32'({PWRITE, PWDATA}), 32'({last_pwrite, last_pwdata}));
  endtask

  initial begin
    int nrsp;
    logic [7:0] a;

    // Reset state
    repeat (3) @(negedge PCLK);
    chk("rst_flags", 32'({cmd_ready, rsp_valid, rsp_err, PSEL1, PSEL2, PENABLE, PWRITE}), 32'd0);
    chk("rst_bus", 32'({PADDR, PWDATA, rsp_rdata}), 32'd0);
    PRESET = 1'b0;
    #1;
    chk("ready_before_edge", 32'(cmd_ready), 32'd0);
    @(negedge PCLK);
    chk("ready_after_edge", 32'(cmd_ready), 32'd1);

    // Directed scenarios
    do_txn(1'b1, 8'h05, 8'hA5, 2, 1'b0, 8'h00);   // write, ready on 3rd ACCESS
    idle(2);
    do_txn(1'b0, 8'h47, 8'h00, 0, 1'b1, 8'h3C);   // zero-wait read of slave 2
    do_txn(1'b0, 8'hC0, 8'h11, 0, 1'b1, 8'h00);   // decode error
    do_txn(1'b1, 8'h12, 8'h77, 50, 1'b1, 8'h00);  // timeout
    do_txn(1'b0, 8'h20, 8'h00, 1, 1'b1, 8'h9E);   // back-to-back after abort
    do_txn(1'b1, 8'h61, 8'h5A, 3, 1'b0, 8'h00);   // slave 2 at TIMEOUT-1 waits
    idle(1);

    // Reset in the middle of an ACCESS phase
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h10; cmd_wdata = 8'h00;
    PREADY1 = 1'b0; PREADY2 = 1'b1;
    @(posedge PCLK);
    #1 cmd_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("pre_rst_access", 32'({PSEL1, PENABLE}), 32'd3);
    #2 PRESET = 1'b1;
    #1;
    chk("async_drop", 32'({PSEL1, PSEL2, PENABLE, rsp_valid, cmd_ready}), 32'd0);
    @(negedge PCLK);
    PRESET = 1'b0;
    last_paddr = 8'h00; last_pwdata = 8'h00; last_pwrite = 1'b0;
    chk("rst_paddr", 32'({PADDR, PWDATA}), 32'd0);
    nrsp = 0;
    @(negedge PCLK);
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);
    if (rsp_valid) nrsp++;
    repeat (3) begin
      @(negedge PCLK);
      if (rsp_valid) nrsp++;
    end
    chk("no_rsp_after_rst", 32'(nrsp), 32'd0);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      a = 8'($urandom);
      if ($urandom_range(0, 5) != 0) a[7] = 1'b0;
      do_txn(1'($urandom), a, 8'($urandom), $urandom_range(0, 6),
             1'($urandom), 8'($urandom));
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
